key_irq_ctrl: RTL

Button-event interrupt controller for the 8-bit LED-matrix CPU. It synchronises and debounces the six front-panel keys, generates press and auto-repeat events, and holds them as pending requests. It arbitrates by fixed priority and presents one jump vector at a time to the CPU's interrupt entry over a req/ack handshake, honouring the CPU's `di` mask. It replaces the CPU's direct sampling of raw buttons into R5.

---
 rtl/key_irq_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/key_irq_ctrl.sv
// Front-panel key interrupt controller: synchronises and debounces six active-low keys,
// raises press/auto-repeat events as pending flags and presents one vector at a time to the CPU.
module key_irq_ctrl #(
    parameter logic [15:0] TICK_DIV  = 16'd48000,
    parameter logic [3:0]  DEB_TICKS = 4'd8,
    parameter logic [7:0]  RPT_DELAY = 8'd50,
    parameter logic [7:0]  RPT_RATE  = 8'd10,
    parameter logic [7:0]  VEC_BASE  = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] keys_n,
    input  logic       di,
    input  logic       irq_ack,
    output logic       irq_req,
    output logic [7:0] irq_vec,
    output logic [5:0] key_state,
    output logic [5:0] pending,
    output logic       overrun
);

    localparam int NK = 6;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_GAP     = 2'd2;

    logic [5:0]  sync1_q, sync2_q;
    logic [5:0]  key_s;
    logic [15:0] presc_q, presc_d;
    logic        tick_s;
    logic [3:0]  deb_q [NK];
    logic [3:0]  deb_d [NK];
    logic [7:0]  rpt_q [NK];
    logic [7:0]  rpt_d [NK];
    logic [5:0]  ks_q, ks_d;
    logic [5:0]  flip_s, press_s, rpt_ev_s, ev_s, clr_s;
    logic [5:0]  pend_q, pend_d;
    logic        ovr_q, ovr_d;
    logic [1:0]  st_q, st_d;
    logic [2:0]  sel_q, sel_d, win_s;
    logic        req_q, req_d;
    logic [7:0]  vec_q, vec_d;

    function automatic logic [2:0] lowest_set(input logic [5:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NK - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign key_s  = ~sync2_q;
    assign tick_s = (presc_q == (TICK_DIV - 16'd1));
    assign win_s  = lowest_set(pend_q);

    // Prescaler wraps to zero on the tick cycle.
    always_comb begin
        if (tick_s) begin
            presc_d = 16'd0;
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    // Per-key debounce and auto-repeat; repeat keeps running while a release is still being debounced.
    always_comb begin
        ks_d     = ks_q;
        flip_s   = 6'd0;
        press_s  = 6'd0;
        rpt_ev_s = 6'd0;
        for (int i = 0; i < NK; i++) begin
            deb_d[i] = deb_q[i];
            rpt_d[i] = rpt_q[i];
            if (tick_s && (key_s[i] != ks_q[i])) begin
                if ((deb_q[i] + 4'd1) == DEB_TICKS) begin
                    flip_s[i] = 1'b1;
                    ks_d[i]   = key_s[i];
                    deb_d[i]  = 4'd0;
                    if (key_s[i]) begin
                        press_s[i] = 1'b1;
                        rpt_d[i]   = RPT_DELAY;
                    end else begin
                        rpt_d[i] = 8'd0;
                    end
                end else begin
                    deb_d[i] = deb_q[i] + 4'd1;
                end
            end else if (tick_s) begin
                deb_d[i] = 4'd0;
            end else begin
                deb_d[i] = deb_q[i];
            end
            if (tick_s && !flip_s[i] && ks_q[i] && (RPT_DELAY != 8'd0)) begin
                if (rpt_q[i] == 8'd1) begin
                    rpt_ev_s[i] = 1'b1;
                    rpt_d[i]    = RPT_RATE;
                end else begin
                    rpt_d[i] = rpt_q[i] - 8'd1;
                end
            end else begin
                rpt_d[i] = rpt_d[i];
            end
        end
    end

    // Presentation FSM; an ack takes precedence over a simultaneous di.
    always_comb begin
        st_d  = st_q;
        sel_d = sel_q;
        vec_d = vec_q;
        clr_s = 6'd0;
        case (st_q)
            ST_IDLE: begin
                if (!di && (pend_q != 6'd0)) begin
                    sel_d = win_s;
                    vec_d = VEC_BASE + {4'd0, win_s, 1'b0};
                    st_d  = ST_PRESENT;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (irq_ack) begin
                    clr_s = 6'd1 << sel_q;
                    st_d  = ST_GAP;
                end else if (di) begin
                    st_d = ST_IDLE;
                end else begin
                    st_d = ST_PRESENT;
                end
            end
            ST_GAP: begin
                st_d = ST_IDLE;
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
        req_d = (st_d == ST_PRESENT);
    end

    // A new event beats a same-edge clear and then does not count as an overrun.
    always_comb begin
        ev_s   = press_s | rpt_ev_s;
        pend_d = (pend_q & ~clr_s) | ev_s;
        ovr_d  = ovr_q | (|(ev_s & pend_q & ~clr_s));
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 6'h3F;
            sync2_q <= 6'h3F;
            presc_q <= 16'd0;
            ks_q    <= 6'd0;
            pend_q  <= 6'd0;
            ovr_q   <= 1'b0;
            st_q    <= ST_IDLE;
            sel_q   <= 3'd0;
            req_q   <= 1'b0;
            vec_q   <= VEC_BASE;
            for (int i = 0; i < NK; i++) begin
                deb_q[i] <= 4'd0;
                rpt_q[i] <= 8'd0;
            end
        end else begin
            sync1_q <= keys_n;
            sync2_q <= sync1_q;
            presc_q <= presc_d;
            ks_q    <= ks_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            st_q    <= st_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            for (int i = 0; i < NK; i++) begin
                deb_q[i] <= deb_d[i];
                rpt_q[i] <= rpt_d[i];
            end
        end
    end

    assign irq_req   = req_q;
    assign irq_vec   = vec_q;
    assign key_state = ks_q;
    assign pending   = pend_q;
    assign overrun   = ovr_q;

endmodule
